// File: rtl/spi_master_arbiter_if.sv
// spi_master_arbiter_if: requester handshakes and SPI master config/data
// channels bundled for spi_master_arbiter. The master modport is the arbiter's
// view. The slave modport is the view of the clients and the SPI master.
interface spi_master_arbiter_if #(
  parameter int nreqs    = 2,
  parameter int nbits    = 34,
  parameter int logBitsN = $clog2(nbits) + 1,
  parameter int logCSN   = 1
);
  logic [nreqs-1:0]          req_val;
  logic [nreqs-1:0]          req_rdy;
  logic [nreqs*nbits-1:0]    req_msg;
  logic [nreqs*logBitsN-1:0] req_pkt_size;
  logic [nreqs*logCSN-1:0]   req_cs_addr;
  logic [nreqs*3-1:0]        req_freq;

  logic [nreqs-1:0]          resp_val;
  logic [nreqs-1:0]          resp_rdy;
  logic [nbits-1:0]          resp_msg;

  logic                      spi_recv_val;
  logic                      spi_recv_rdy;
  logic [nbits-1:0]          spi_recv_msg;
  logic                      spi_pkt_size_val;
  logic                      spi_pkt_size_rdy;
  logic [logBitsN-1:0]       spi_pkt_size_msg;
  logic                      spi_cs_addr_val;
  logic                      spi_cs_addr_rdy;
  logic [logCSN-1:0]         spi_cs_addr_msg;
  logic                      spi_freq_val;
  logic                      spi_freq_rdy;
  logic [2:0]                spi_freq_msg;
  logic                      spi_send_val;
  logic                      spi_send_rdy;
  logic [nbits-1:0]          spi_send_msg;

  modport master (
    input  req_val, req_msg, req_pkt_size, req_cs_addr, req_freq, resp_rdy,
    input  spi_recv_rdy, spi_pkt_size_rdy, spi_cs_addr_rdy, spi_freq_rdy,
    input  spi_send_val, spi_send_msg,
    output req_rdy, resp_val, resp_msg,
    output spi_recv_val, spi_recv_msg, spi_pkt_size_val, spi_pkt_size_msg,
    output spi_cs_addr_val, spi_cs_addr_msg, spi_freq_val, spi_freq_msg,
    output spi_send_rdy
  );

  modport slave (
    output req_val, req_msg, req_pkt_size, req_cs_addr, req_freq, resp_rdy,
    output spi_recv_rdy, spi_pkt_size_rdy, spi_cs_addr_rdy, spi_freq_rdy,
    output spi_send_val, spi_send_msg,
    input  req_rdy, resp_val, resp_msg,
    input  spi_recv_val, spi_recv_msg, spi_pkt_size_val, spi_pkt_size_msg,
    input  spi_cs_addr_val, spi_cs_addr_msg, spi_freq_val, spi_freq_msg,
    input  spi_send_rdy
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin sharing of one SPI master among nreqs clients.
// Flow: IDLE (grant) -> CFG (load pkt_size/cs/freq) -> XFER (recv) -> WAIT (send)
// -> RESP (return the result to the granted client).
// Optional macro SPI_ARB_CFG_CACHE_EN adds a shadow of the last accepted config.
// When the shadow matches the granted request, CFG is skipped.
module spi_master_arbiter #(
  parameter int nreqs    = 2,
  parameter int nbits    = 34,
  parameter int logBitsN = $clog2(nbits) + 1,
  parameter int logCSN   = 1
) (
  input  logic                 clk,
  input  logic                 reset,   // asynchronous, active low
  spi_master_arbiter_if.master bus
);
  localparam int PW = $clog2(nreqs);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CFG  = 3'd1;
  localparam logic [2:0] XFER = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]       grant_q, grant_d;
  logic [nbits-1:0]    msg_q, msg_d;
  logic [logBitsN-1:0] pkt_q, pkt_d;
  logic [logCSN-1:0]   cs_q, cs_d;
  logic [2:0]          freq_q, freq_d;
  logic [nbits-1:0]    resp_q, resp_d;

  logic [nbits-1:0]    msg_a  [nreqs];
  logic [logBitsN-1:0] pkt_a  [nreqs];
  logic [logCSN-1:0]   cs_a   [nreqs];
  logic [2:0]          freq_a [nreqs];

  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic                cache_hit;

  // The other config channels are accepted together with pkt_size by the master.
  logic unused_cfg_rdy;
  assign unused_cfg_rdy = &{1'b0, bus.spi_cs_addr_rdy, bus.spi_freq_rdy};

  genvar gi;
  generate
    for (gi = 0; gi < nreqs; gi++) begin : g_unpack
      assign msg_a[gi]  = bus.req_msg[gi*nbits +: nbits];
      assign pkt_a[gi]  = bus.req_pkt_size[gi*logBitsN +: logBitsN];
      assign cs_a[gi]   = bus.req_cs_addr[gi*logCSN +: logCSN];
      assign freq_a[gi] = bus.req_freq[gi*3 +: 3];
    end
  endgenerate

  // (base + offs) mod nreqs, for offs in 0..nreqs-1
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= nreqs) s = s - nreqs;
    return PW'(s);
  endfunction

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int k = 0; k < nreqs; k++) begin
      if (!win_found && bus.req_val[wrap_add(rr_ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

`ifdef SPI_ARB_CFG_CACHE_EN
  logic                shadow_vld_q;
  logic [logBitsN-1:0] shadow_pkt_q;
  logic [logCSN-1:0]   shadow_cs_q;
  logic [2:0]          shadow_freq_q;

  // Remember the configuration the master last accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_vld_q  <= 1'b0;
      shadow_pkt_q  <= '0;
      shadow_cs_q   <= '0;
      shadow_freq_q <= '0;
    end else if (state_q == CFG && bus.spi_pkt_size_rdy) begin
      shadow_vld_q  <= 1'b1;
      shadow_pkt_q  <= pkt_q;
      shadow_cs_q   <= cs_q;
      shadow_freq_q <= freq_q;
    end
  end

  assign cache_hit = shadow_vld_q &&
                     (pkt_a[win_idx]  == shadow_pkt_q) &&
                     (cs_a[win_idx]   == shadow_cs_q) &&
                     (freq_a[win_idx] == shadow_freq_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Sequencer next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    msg_d    = msg_q;
    pkt_d    = pkt_q;
    cs_d     = cs_q;
    freq_d   = freq_q;
    resp_d   = resp_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          msg_d   = msg_a[win_idx];
          pkt_d   = pkt_a[win_idx];
          cs_d    = cs_a[win_idx];
          freq_d  = freq_a[win_idx];
          state_d = cache_hit ? XFER : CFG;
        end
      end
      CFG:  if (bus.spi_pkt_size_rdy) state_d = XFER;
      XFER: if (bus.spi_recv_rdy) state_d = WAIT;
      WAIT: begin
        if (bus.spi_send_val) begin
          resp_d  = bus.spi_send_msg;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_rdy[grant_q]) begin
          rr_ptr_d = wrap_add(grant_q, 1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      msg_q    <= '0;
      pkt_q    <= '0;
      cs_q     <= '0;
      freq_q   <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      msg_q    <= msg_d;
      pkt_q    <= pkt_d;
      cs_q     <= cs_d;
      freq_q   <= freq_d;
      resp_q   <= resp_d;
    end
  end

  // Grant strobe goes to the winner only. It is forced low while reset is held.
  always_comb begin
    bus.req_rdy = '0;
    if (reset && state_q == IDLE && win_found) bus.req_rdy[win_idx] = 1'b1;
  end

  // The response is presented to the granted requester only
  always_comb begin
    bus.resp_val = '0;
    if (state_q == RESP) bus.resp_val[grant_q] = 1'b1;
  end

  assign bus.resp_msg         = resp_q;
  assign bus.spi_pkt_size_val = (state_q == CFG);
  assign bus.spi_cs_addr_val  = (state_q == CFG);
  assign bus.spi_freq_val     = (state_q == CFG);
  assign bus.spi_pkt_size_msg = pkt_q;
  assign bus.spi_cs_addr_msg  = cs_q;
  assign bus.spi_freq_msg     = freq_q;
  assign bus.spi_recv_val     = (state_q == XFER);
  assign bus.spi_recv_msg     = msg_q;
  assign bus.spi_send_rdy     = (state_q == WAIT);
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: table-driven transactions against a small SPI master
// model, plus hand-written reset, backpressure and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_spi_master_arbiter;
  localparam int NR = 2;
  localparam int NB = 34;
  localparam int LB = $clog2(NB) + 1;
  localparam int LC = 1;
`ifdef SPI_ARB_CFG_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 2;
`endif

  typedef struct {
    logic [1:0]    val;
    logic [NB-1:0] msg0, msg1;
    logic [LB-1:0] pkt0, pkt1;
    logic [LC-1:0] cs0, cs1;
    logic [2:0]    fr0, fr1;
    logic [NB-1:0] miso;
    int            exp_grant;
    int            exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.nreqs(NR), .nbits(NB), .logBitsN(LB), .logCSN(LC)) bus ();

  spi_master_arbiter #(.nreqs(NR), .nbits(NB), .logBitsN(LB), .logCSN(LC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // requester side
  logic [1:0]    tb_val = 2'b00;
  logic [1:0]    tb_resp_rdy = 2'b11;
  logic [NB-1:0] f_msg  [2];
  logic [LB-1:0] f_pkt  [2];
  logic [LC-1:0] f_cs   [2];
  logic [2:0]    f_freq [2];
  assign bus.req_val      = tb_val;
  assign bus.resp_rdy     = tb_resp_rdy;
  assign bus.req_msg      = {f_msg[1], f_msg[0]};
  assign bus.req_pkt_size = {f_pkt[1], f_pkt[0]};
  assign bus.req_cs_addr  = {f_cs[1], f_cs[0]};
  assign bus.req_freq     = {f_freq[1], f_freq[0]};

  // SPI master model: always ready for config/recv, answers 4 cycles after recv
  logic          m_send_val;
  logic [NB-1:0] m_send_msg;
  logic [NB-1:0] miso_word = '0;
  assign bus.spi_recv_rdy     = 1'b1;
  assign bus.spi_pkt_size_rdy = 1'b1;
  assign bus.spi_cs_addr_rdy  = 1'b1;
  assign bus.spi_freq_rdy     = 1'b1;
  assign bus.spi_send_val     = m_send_val;
  assign bus.spi_send_msg     = m_send_msg;

  int cyc = 0;
  int cfg_edge = 0, recv_edge = 0, send_edge = 0, cfg_cnt = 0, cd = 0;
  logic [LB-1:0] cfg_pkt;
  logic [LC-1:0] cfg_cs;
  logic [2:0]    cfg_freq;
  logic [NB-1:0] rec_msg;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_send_val <= 1'b0;
      m_send_msg <= '0;
      cd         <= 0;
    end else begin
      if (bus.spi_pkt_size_val) begin
        cfg_edge <= cyc + 1;
        cfg_cnt  <= cfg_cnt + 1;
        cfg_pkt  <= bus.spi_pkt_size_msg;
        cfg_cs   <= bus.spi_cs_addr_msg;
        cfg_freq <= bus.spi_freq_msg;
      end
      if (bus.spi_recv_val) begin
        recv_edge <= cyc + 1;
        rec_msg   <= bus.spi_recv_msg;
        cd        <= 3;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          m_send_val <= 1'b1;
          m_send_msg <= miso_word;
        end
      end
      if (m_send_val && bus.spi_send_rdy) begin
        m_send_val <= 1'b0;
        send_edge  <= cyc + 1;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Wait (bounded) until some req_val/req_rdy pair is about to fire
  task automatic wait_fire(input string tag, output int g, output int fe);
    g  = -1;
    fe = 0;
    for (int t = 0; t < 20; t++) begin
      if ((bus.req_val & bus.req_rdy) != 2'b00) begin
        g  = bus.req_rdy[1] ? 1 : 0;
        fe = cyc + 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (g < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s fire_timeout: got no req_rdy, expected a grant", tag);
    end
  endtask

  // Wait (bounded) for resp_val, noting any req_rdy seen meanwhile
  task automatic wait_resp(input string tag, output bit quiet, output int re);
    quiet = 1'b1;
    re    = -1;
    for (int t = 0; t < 60; t++) begin
      if (bus.resp_val != 2'b00) begin
        re = cyc;
        break;
      end
      if (bus.req_rdy != 2'b00) quiet = 1'b0;
      @(posedge clk); #1;
    end
    if (re < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s resp_timeout: got no resp_val, expected a response", tag);
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int g, fe, c0, re;
    bit quiet;
    logic [NB-1:0] e_msg;
    logic [LB-1:0] e_pkt;
    logic [LC-1:0] e_cs;
    logic [2:0]    e_fr;
    f_msg[0] = v.msg0;  f_msg[1] = v.msg1;
    f_pkt[0] = v.pkt0;  f_pkt[1] = v.pkt1;
    f_cs[0]  = v.cs0;   f_cs[1]  = v.cs1;
    f_freq[0] = v.fr0;  f_freq[1] = v.fr1;
    miso_word = v.miso;
    tb_val    = v.val;
    c0        = cfg_cnt;
    #1;
    wait_fire(tag, g, fe);
    if (g < 0) begin
      tb_val = 2'b00;
      return;
    end
    chk({tag, " grant"}, 64'(g), 64'(v.exp_grant));
    chk({tag, " req_rdy"}, 64'(bus.req_rdy), 64'(2'b01 << v.exp_grant));
    @(posedge clk); #1;
    tb_val[g] = 1'b0;               // losers keep requesting
    wait_resp(tag, quiet, re);
    if (re < 0) begin
      tb_val = 2'b00;
      return;
    end
    e_msg = (v.exp_grant == 0) ? v.msg0 : v.msg1;
    e_pkt = (v.exp_grant == 0) ? v.pkt0 : v.pkt1;
    e_cs  = (v.exp_grant == 0) ? v.cs0  : v.cs1;
    e_fr  = (v.exp_grant == 0) ? v.fr0  : v.fr1;
    chk({tag, " latency"}, 64'(recv_edge - fe), 64'(v.exp_lat));
    chk({tag, " recv_msg"}, 64'(rec_msg), 64'(e_msg));
    chk({tag, " cfg_fires"}, 64'(cfg_cnt - c0), (v.exp_lat == 2) ? 64'd1 : 64'd0);
    if (v.exp_lat == 2) begin
      chk({tag, " cfg_to_recv"}, 64'(recv_edge - cfg_edge), 64'd1);
      chk({tag, " cfg_pkt"}, 64'(cfg_pkt), 64'(e_pkt));
      chk({tag, " cfg_cs"}, 64'(cfg_cs), 64'(e_cs));
      chk({tag, " cfg_freq"}, 64'(cfg_freq), 64'(e_fr));
    end
    chk({tag, " resp_delay"}, 64'(re - send_edge), 64'd0);
    chk({tag, " resp_val"}, 64'(bus.resp_val), 64'(2'b01 << v.exp_grant));
    chk({tag, " resp_msg"}, 64'(bus.resp_msg), 64'(v.miso));
    chk({tag, " no_rdy_busy"}, 64'(quiet), 64'd1);
    $display("[TB] %s grant=%0d lat=%0d resp=0x%0h", tag, g, recv_edge - fe, bus.resp_msg);
    @(posedge clk); #1;
    tb_val = 2'b00;
  endtask

  vec_t tbl [8];
  vec_t vr;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, fe;
    bit quiet, stable, found;
    int re;

    tbl[0] = '{2'b01, 34'h2A5, 34'h0, 7'd10, 7'd0, 1'b0, 1'b0, 3'd0, 3'd0, 34'h1C3, 0, 2};
    tbl[1] = '{2'b10, 34'h0, 34'h0AB, 7'd0, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h055, 1, 2};
    tbl[2] = '{2'b11, 34'h3_0000_0001, 34'h1_2345, 7'd34, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h2_AAAA_5555, 0, 2};
    tbl[3] = '{2'b11, 34'h3_0000_0001, 34'h1_2345, 7'd34, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h1_5555_AAAA, 1, 2};
    tbl[4] = '{2'b11, 34'h3_0000_0001, 34'h1_2345, 7'd34, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h0_000F_0F0F, 0, 2};
    tbl[5] = '{2'b11, 34'h3_0000_0001, 34'h1_2345, 7'd34, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h3_FFFF_FFFF, 1, 2};
    tbl[6] = '{2'b10, 34'h0, 34'h0_BEEF, 7'd0, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h777, 1, HIT_LAT};
    tbl[7] = '{2'b10, 34'h0, 34'h0_CAFE, 7'd0, 7'd8, 1'b0, 1'b1, 3'd0, 3'd3, 34'h1234, 1, 2};
    vr     = '{2'b11, 34'h2A5, 34'h0_0F00, 7'd10, 7'd8, 1'b0, 1'b1, 3'd0, 3'd2, 34'h1C3, 0, 2};

    for (int i = 0; i < 2; i++) begin
      f_msg[i] = '0; f_pkt[i] = '0; f_cs[i] = '0; f_freq[i] = '0;
    end

    // reset state, with both requesters already asserting
    tb_val = 2'b11;
    @(posedge clk); #1;
    chk("rst req_rdy", 64'(bus.req_rdy), 64'd0);
    chk("rst resp_val", 64'(bus.resp_val), 64'd0);
    chk("rst resp_msg", 64'(bus.resp_msg), 64'd0);
    chk("rst spi_vals", 64'({bus.spi_recv_val, bus.spi_pkt_size_val, bus.spi_cs_addr_val,
                              bus.spi_freq_val, bus.spi_send_rdy}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst rr_ptr0", 64'(bus.req_rdy), 64'(2'b01));
    tb_val = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_txn($sformatf("v%0d", i), tbl[i]);

    // response backpressure on requester 1 while requester 0 waits
    f_msg[1] = 34'h2_1357_9BDF; f_pkt[1] = 7'd12; f_cs[1] = 1'b1; f_freq[1] = 3'd5;
    miso_word = 34'h1_ABCD_0123;
    tb_resp_rdy = 2'b01;
    tb_val = 2'b10;
    #1;
    wait_fire("bp", g, fe);
    chk("bp grant", 64'(g), 64'd1);
    @(posedge clk); #1;
    tb_val = 2'b11;
    wait_resp("bp", quiet, re);
    chk("bp resp_val", 64'(bus.resp_val), 64'(2'b10));
    chk("bp resp_msg", 64'(bus.resp_msg), 64'(34'h1_ABCD_0123));
    stable = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk); #1;
      if (bus.resp_val !== 2'b10 || bus.resp_msg !== 34'h1_ABCD_0123 || bus.req_rdy !== 2'b00)
        stable = 1'b0;
    end
    chk("bp hold_stable", 64'(stable), 64'd1);
    tb_resp_rdy = 2'b11;
    @(posedge clk); #1;
    chk("bp released resp_val", 64'(bus.resp_val), 64'd0);
    chk("bp next req_rdy", 64'(bus.req_rdy), 64'(2'b01));
    $display("[TB] bp grant=1 held 20 cycles resp=0x%0h", miso_word);
    tb_val = 2'b00;
    @(posedge clk); #1;

    // reset in WAIT
    f_msg[0] = 34'h2A5; f_pkt[0] = 7'd10; f_cs[0] = 1'b0; f_freq[0] = 3'd0;
    miso_word = 34'h3_3333_3333;
    tb_val = 2'b01;
    #1;
    wait_fire("mrst", g, fe);
    chk("mrst grant", 64'(g), 64'd0);
    @(posedge clk); #1;
    tb_val = 2'b11;
    found = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (bus.spi_send_rdy) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("mrst reached_wait", 64'(found), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst req_rdy", 64'(bus.req_rdy), 64'd0);
    chk("mrst resp_val", 64'(bus.resp_val), 64'd0);
    chk("mrst resp_msg", 64'(bus.resp_msg), 64'd0);
    chk("mrst spi_vals", 64'({bus.spi_recv_val, bus.spi_pkt_size_val, bus.spi_cs_addr_val,
                               bus.spi_freq_val, bus.spi_send_rdy}), 64'd0);
    $display("[TB] mrst reset asserted in WAIT");
    @(posedge clk); #1;
    reset = 1'b1;
    tb_val = 2'b00;
    run_txn("post_rst", vr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
